stack_ctl: RTL and testbench

Sequencer that sits directly upstream of the `lifo` stack and turns single-instruction requests into `lifo` push/pop/data controls. It decodes a 4-bit stack opcode and computes arithmetic/logic results from the `lifo` top two elements (`o_s0`/`o_s1`). It optionally tracks stack depth to reject overflow and underflow. Multi-step operations (SWAP) run as a short FSM behind a valid/ready handshake.

---
 rtl/stack_pkg.sv | 45 ++++
 rtl/stack_ctl_if.sv | 29 ++
 rtl/stack_alu.sv | 26 ++
 rtl/stack_ctl.sv | 201 ++++++++++++++++++++
 tb/tb_stack_ctl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared opcodes, FSM state encoding and opcode decode helpers for the stack controller.
package stack_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_DROP = 4'd2;
    localparam logic [3:0] OP_DUP  = 4'd3;
    localparam logic [3:0] OP_SWAP = 4'd4;
    localparam logic [3:0] OP_OVER = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_SUB  = 4'd9;
    localparam logic [3:0] OP_AND  = 4'd10;
    localparam logic [3:0] OP_OR   = 4'd11;
    localparam logic [3:0] OP_XOR  = 4'd12;
    localparam logic [3:0] OP_NOT  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ALU_PUT = 2'd1,
        ST_SW_PUT  = 2'd2,
        ST_SW_PUSH = 2'd3
    } state_t;

    // Unassigned opcodes decode to NOP.
    function automatic logic op_is_reserved(input logic [3:0] op);
        return (op == 4'd6) || (op == 4'd7) || (op == 4'd14) || (op == 4'd15);
    endfunction

    function automatic logic op_is_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic op_needs_one(input logic [3:0] op);
        return (op == OP_DROP) || (op == OP_DUP) || (op == OP_NOT);
    endfunction

    function automatic logic op_needs_two(input logic [3:0] op);
        return (op == OP_SWAP) || (op == OP_OVER) || op_is_alu(op);
    endfunction

    function automatic logic op_grows(input logic [3:0] op);
        return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

endpackage

// File: rtl/stack_ctl_if.sv
// Request/response handshake plus lifo control/observation bundle of the stack controller.
interface stack_ctl_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       op;
    logic [WIDTH-1:0] imm;
    logic             valid;
    logic             ready;
    logic             done;
    logic             overflow;
    logic             underflow;
    logic [3:0]       depth;
    logic [WIDTH-1:0] data;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;

    // master: requester together with the lifo; slave: the controller.
    modport master (
        output op, imm, valid, s0, s1,
        input  ready, done, overflow, underflow, depth, data, push, pop
    );

    modport slave (
        input  op, imm, valid, s0, s1,
        output ready, done, overflow, underflow, depth, data, push, pop
    );
endinterface

// File: rtl/stack_alu.sv
// Combinational ALU for the stack controller: result of b op a, wrapping modulo 2^WIDTH.
module stack_alu
    import stack_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = b + a;
            OP_SUB:  result = b - a;
            OP_AND:  result = b & a;
            OP_OR:   result = b | a;
            OP_XOR:  result = b ^ a;
            OP_NOT:  result = ~a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/stack_ctl.sv
// Stack sequencer: turns opcode requests into push/pop/data controls for a lifo.
// Define STACK_CHECK_EN to enable depth tracking with overflow/underflow rejection.
module stack_ctl
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12
) (
    input  logic       i_clk,
    input  logic       i_rst,
    stack_ctl_if.slave bus
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] opa_reg, opa_next;
    logic [WIDTH-1:0] opb_reg, opb_next;
    logic             done_reg, done_next;
    logic             uf_reg, uf_next;
    logic             of_reg, of_next;

    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] data_c;
    logic             push_c, pop_c;
    logic             accept;
    logic             reject_uf, reject_of;
    logic [3:0]       op_eff;

    assign op_eff = op_is_reserved(bus.op) ? OP_NOP : bus.op;
    assign accept = bus.valid && bus.ready;

    stack_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (op_eff),
        .a      (bus.s0),
        .b      (bus.s1),
        .result (alu_result)
    );

`ifdef STACK_CHECK_EN
    localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);

    logic [3:0] depth_reg, depth_next;

    // Underflow wins when both conditions could apply.
    assign reject_uf = (op_needs_one(op_eff) && (depth_reg == 4'd0)) ||
                       (op_needs_two(op_eff) && (depth_reg < 4'd2));
    assign reject_of = !reject_uf && op_grows(op_eff) && (depth_reg >= DEPTH_MAX);

    // Depth moves on the op's last execution cycle; ALU ops shrink in ALU_PUT.
    always_comb begin
        depth_next = depth_reg;
        if (state_reg == ST_ALU_PUT) begin
            depth_next = depth_reg - 4'd1;
        end else if (accept && !reject_uf && !reject_of) begin
            if (op_grows(op_eff)) begin
                depth_next = depth_reg + 4'd1;
            end else if (op_eff == OP_DROP) begin
                depth_next = depth_reg - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            depth_reg <= '0;
        end else begin
            depth_reg <= depth_next;
        end
    end

    assign bus.depth = depth_reg;
`else
    assign reject_uf = 1'b0;
    assign reject_of = 1'b0;
    assign bus.depth = '0;
`endif

    always_comb begin
        state_next = state_reg;
        opa_next   = opa_reg;
        opb_next   = opb_reg;
        done_next  = 1'b0;
        uf_next    = 1'b0;
        of_next    = 1'b0;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        data_c     = '0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (reject_uf || reject_of) begin
                        done_next = 1'b1;
                        uf_next   = reject_uf;
                        of_next   = reject_of;
                    end else begin
                        case (op_eff)
                            OP_PUSH: begin
                                push_c    = 1'b1;
                                data_c    = bus.imm;
                                done_next = 1'b1;
                            end
                            OP_DROP: begin
                                pop_c     = 1'b1;
                                done_next = 1'b1;
                            end
                            OP_DUP: begin
                                push_c    = 1'b1;
                                data_c    = bus.s0;
                                done_next = 1'b1;
                            end
                            OP_OVER: begin
                                push_c    = 1'b1;
                                data_c    = bus.s1;
                                done_next = 1'b1;
                            end
                            OP_NOT: begin
                                push_c    = 1'b1;
                                pop_c     = 1'b1;
                                data_c    = alu_result;
                                done_next = 1'b1;
                            end
                            OP_SWAP: begin
                                pop_c      = 1'b1;
                                opa_next   = bus.s0;
                                opb_next   = bus.s1;
                                state_next = ST_SW_PUT;
                            end
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                                // Result is captured now because the pop below changes s0/s1.
                                pop_c      = 1'b1;
                                opa_next   = alu_result;
                                state_next = ST_ALU_PUT;
                            end
                            default: begin
                                done_next = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_ALU_PUT: begin
                push_c     = 1'b1;
                pop_c      = 1'b1;
                data_c     = opa_reg;
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            ST_SW_PUT: begin
                push_c     = 1'b1;
                pop_c      = 1'b1;
                data_c     = opa_reg;
                state_next = ST_SW_PUSH;
            end
            ST_SW_PUSH: begin
                push_c     = 1'b1;
                data_c     = opb_reg;
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // An in-flight sequence must not touch the lifo while reset is held.
        if (i_rst) begin
            push_c = 1'b0;
            pop_c  = 1'b0;
            data_c = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            opa_reg   <= '0;
            opb_reg   <= '0;
            done_reg  <= 1'b0;
            uf_reg    <= 1'b0;
            of_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            done_reg  <= done_next;
            uf_reg    <= uf_next;
            of_reg    <= of_next;
        end
    end

    assign bus.ready     = (state_reg == ST_IDLE) && !i_rst;
    assign bus.done      = done_reg;
    assign bus.underflow = uf_reg;
    assign bus.overflow  = of_reg;
    assign bus.push      = push_c;
    assign bus.pop       = pop_c;
    assign bus.data      = data_c;

endmodule

// File: tb/tb_stack_ctl.sv
// Directed, table-driven bench for stack_ctl with a behavioural 12-entry lifo model.
module tb_stack_ctl;
    import stack_pkg::*;

`ifdef STACK_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    typedef struct {
        logic [3:0] op;
        logic [7:0] imm;
        logic [7:0] s0;
        logic [7:0] s1;
        int         depth;
        int         lat;
        int         uf;
        int         push;
        int         pop;
    } vec_t;

    localparam int NV = 23;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    stack_ctl_if #(.WIDTH(8)) bus ();

    stack_ctl #(
        .WIDTH (8),
        .DEPTH (12)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural lifo: push+pop replaces the top, full pushes and empty pops are ignored.
    logic [7:0] mem [0:15];
    logic [3:0] sp;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= 4'd0;
        end else if (bus.push && bus.pop) begin
            if (sp > 4'd0) mem[sp - 4'd1] <= bus.data;
        end else if (bus.push) begin
            if (sp < 4'd12) begin
                mem[sp] <= bus.data;
                sp      <= sp + 4'd1;
            end
        end else if (bus.pop) begin
            if (sp > 4'd0) sp <= sp - 4'd1;
        end
    end

    always_comb begin
        bus.s0 = (sp > 4'd0) ? mem[sp - 4'd1] : 8'h00;
        bus.s1 = (sp > 4'd1) ? mem[sp - 4'd2] : 8'h00;
    end

    function automatic int ed(input int d);
        return (CHK != 0) ? d : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        bus.valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [7:0] imm,
                          output int lat, output int rdy_low, output int uf,
                          output int of, output int apush, output int apop);
        @(negedge clk);
        bus.op    = op;
        bus.imm   = imm;
        bus.valid = 1'b1;
        #1;
        apush = int'(bus.push);
        apop  = int'(bus.pop);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        lat     = 1;
        rdy_low = bus.ready ? 0 : 1;
        while (!bus.done && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            if (!bus.ready) rdy_low++;
        end
        uf = int'(bus.underflow);
        of = int'(bus.overflow);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [NV];
        int lat, rl, uf, of, ap, aq, ndone;

        bus.valid = 1'b0;
        bus.op    = OP_NOP;
        bus.imm   = 8'h00;

        //             op       imm    s0     s1     depth   lat            uf   push     pop
        vecs[0]  = '{OP_PUSH, 8'h05, 8'h05, 8'h00, ed(1), 1,             0,   1,       0};
        vecs[1]  = '{OP_PUSH, 8'h03, 8'h03, 8'h05, ed(2), 1,             0,   1,       0};
        vecs[2]  = '{OP_ADD,  8'h00, 8'h08, 8'h00, ed(1), 2,             0,   0,       1};
        vecs[3]  = '{OP_PUSH, 8'h11, 8'h11, 8'h08, ed(2), 1,             0,   1,       0};
        vecs[4]  = '{OP_PUSH, 8'h22, 8'h22, 8'h11, ed(3), 1,             0,   1,       0};
        vecs[5]  = '{OP_SWAP, 8'h00, 8'h11, 8'h22, ed(3), 3,             0,   0,       1};
        vecs[6]  = '{OP_PUSH, 8'h02, 8'h02, 8'h11, ed(4), 1,             0,   1,       0};
        vecs[7]  = '{OP_PUSH, 8'h05, 8'h05, 8'h02, ed(5), 1,             0,   1,       0};
        vecs[8]  = '{OP_SUB,  8'h00, 8'hFD, 8'h11, ed(4), 2,             0,   0,       1};
        vecs[9]  = '{OP_NOT,  8'h00, 8'h02, 8'h11, ed(4), 1,             0,   1,       1};
        vecs[10] = '{OP_OVER, 8'h00, 8'h11, 8'h02, ed(5), 1,             0,   1,       0};
        vecs[11] = '{OP_DUP,  8'h00, 8'h11, 8'h11, ed(6), 1,             0,   1,       0};
        vecs[12] = '{OP_XOR,  8'h00, 8'h00, 8'h02, ed(5), 2,             0,   0,       1};
        vecs[13] = '{OP_OR,   8'h00, 8'h02, 8'h11, ed(4), 2,             0,   0,       1};
        vecs[14] = '{OP_AND,  8'h00, 8'h00, 8'h22, ed(3), 2,             0,   0,       1};
        vecs[15] = '{OP_DROP, 8'h00, 8'h22, 8'h08, ed(2), 1,             0,   0,       1};
        vecs[16] = '{OP_NOP,  8'h77, 8'h22, 8'h08, ed(2), 1,             0,   0,       0};
        vecs[17] = '{4'd14,   8'h77, 8'h22, 8'h08, ed(2), 1,             0,   0,       0};
        vecs[18] = '{OP_ADD,  8'h00, 8'h2A, 8'h00, ed(1), 2,             0,   0,       1};
        vecs[19] = '{OP_DROP, 8'h00, 8'h00, 8'h00, ed(0), 1,             0,   0,       1};
        vecs[20] = '{OP_DROP, 8'h00, 8'h00, 8'h00, ed(0), 1,             CHK, 0,       1 - CHK};
        vecs[21] = '{OP_ADD,  8'h00, 8'h00, 8'h00, ed(0), 2 - CHK,       CHK, 0,       1 - CHK};
        vecs[22] = '{OP_PUSH, 8'hAA, 8'hAA, 8'h00, ed(1), 1,             0,   1,       0};

        // Reset state.
        do_reset();
        @(posedge clk);
        #1;
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_push", int'(bus.push), 0);
        chk("rst_pop", int'(bus.pop), 0);
        chk("rst_depth", int'(bus.depth), 0);
        chk("rst_data", int'(bus.data), 0);
        chk("rst_uf", int'(bus.underflow), 0);
        chk("rst_of", int'(bus.overflow), 0);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].imm, lat, rl, uf, of, ap, aq);
            $display("[%0t] op=%0d imm=0x%02h -> s0=0x%02h s1=0x%02h depth=%0d lat=%0d uf=%0d of=%0d",
                     $time, vecs[i].op, vecs[i].imm, bus.s0, bus.s1, bus.depth, lat, uf, of);
            chk($sformatf("v%0d_s0", i), int'(bus.s0), int'(vecs[i].s0));
            chk($sformatf("v%0d_s1", i), int'(bus.s1), int'(vecs[i].s1));
            chk($sformatf("v%0d_depth", i), int'(bus.depth), vecs[i].depth);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_ready_low", i), rl, vecs[i].lat - 1);
            chk($sformatf("v%0d_underflow", i), uf, vecs[i].uf);
            chk($sformatf("v%0d_overflow", i), of, 0);
            chk($sformatf("v%0d_acc_push", i), ap, vecs[i].push);
            chk($sformatf("v%0d_acc_pop", i), aq, vecs[i].pop);
        end

        // Fill to capacity, then one more PUSH.
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            run_op(OP_PUSH, 8'(i), lat, rl, uf, of, ap, aq);
        end
        chk("fill_depth", int'(bus.depth), ed(12));
        run_op(OP_PUSH, 8'hEE, lat, rl, uf, of, ap, aq);
        $display("[%0t] op=PUSH imm=0xee at full -> s0=0x%02h depth=%0d uf=%0d of=%0d",
                 $time, bus.s0, bus.depth, uf, of);
        chk("full_overflow", of, CHK);
        chk("full_underflow", uf, 0);
        chk("full_latency", lat, 1);
        chk("full_acc_push", ap, 1 - CHK);
        chk("full_depth", int'(bus.depth), ed(12));
        chk("full_s0", int'(bus.s0), 8'h0C);

        // Reset while the SWAP sequence sits in SW_PUT.
        do_reset();
        run_op(OP_PUSH, 8'h11, lat, rl, uf, of, ap, aq);
        run_op(OP_PUSH, 8'h22, lat, rl, uf, of, ap, aq);
        @(negedge clk);
        bus.op    = OP_SWAP;
        bus.valid = 1'b1;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        chk("swput_ready", int'(bus.ready), 0);
        rst = 1'b1;
        #1;
        chk("swput_rst_push", int'(bus.push), 0);
        chk("swput_rst_pop", int'(bus.pop), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        $display("[%0t] reset during SW_PUT -> ready=%0d depth=%0d push=%0d pop=%0d",
                 $time, bus.ready, bus.depth, bus.push, bus.pop);
        chk("swrst_ready", int'(bus.ready), 1);
        chk("swrst_depth", int'(bus.depth), 0);
        chk("swrst_done", int'(bus.done), 0);
        chk("swrst_push", int'(bus.push), 0);
        chk("swrst_pop", int'(bus.pop), 0);
        @(posedge clk);
        #1;
        chk("swrst_push_later", int'(bus.push), 0);
        chk("swrst_pop_later", int'(bus.pop), 0);
        chk("swrst_done_later", int'(bus.done), 0);

        // Back-to-back PUSH x4 with valid held.
        do_reset();
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.op    = OP_PUSH;
            bus.imm   = 8'h40 + 8'(k);
            bus.valid = 1'b1;
            #1;
            chk($sformatf("b2b_ready_%0d", k), int'(bus.ready), 1);
            chk($sformatf("b2b_push_%0d", k), int'(bus.push), 1);
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        @(negedge clk);
        bus.valid = 1'b0;
        @(posedge clk);
        #1;
        if (bus.done) ndone++;
        $display("[%0t] back-to-back PUSH x4 -> done pulses=%0d depth=%0d s0=0x%02h s1=0x%02h",
                 $time, ndone, bus.depth, bus.s0, bus.s1);
        chk("b2b_done_count", ndone, 4);
        chk("b2b_depth", int'(bus.depth), ed(4));
        chk("b2b_s0", int'(bus.s0), 8'h43);
        chk("b2b_s1", int'(bus.s1), 8'h42);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
